log_spec_averager: RTL and testbench
====================================

# log_spec_averager

Frame-averaging stage that sits directly downstream of the log-magnitude stage. It consumes the per-bin `log2_mag` stream of each FFT frame and accumulates each bin over 2^AVG_LOG2 consecutive frames in an on-chip accumulator RAM. On the final frame of each group it emits one averaged frame, streamed bin by bin, to the display/packetiser path. It shares the same global-stall backpressure scheme as the rest of the spectrum pipeline.

## Interface
- DATA_WIDTH, 16: width of input log-magnitude and output average.
- FFT_SIZE, 256: bins per frame; power of two, >= 4.
- AVG_LOG2, 2: log2 of frames averaged per output frame; range 0..8.

- clk  in  1  clock.
- resetn  in  1  reset; synchronous, active-low.
- ready_out  in  1  downstream ready; low = global stall.
- ready_in  out  1  equals ready_out (combinational passthrough).
- in_valid  in  1  in_data is a valid bin this cycle.
- in_last  in  1  qualifies the last bin of a frame (meaningful only with in_valid).
- in_data  in  DATA_WIDTH  log2 magnitude, unsigned.
- out_valid  out  1  averaged bin valid.
- out_last  out  1  last bin of an averaged frame.
- out_bin  out  $clog2(FFT_SIZE)  bin index of out_data.
- out_data  out  DATA_WIDTH  averaged log2 magnitude, unsigned.
- err_len  out  1  one-cycle pulse: frame length mismatch detected.

## Operation
- Counters:
  - bin_cnt: $clog2(FFT_SIZE) bits; advances on each accepted valid input.
  - frm_cnt: AVG_LOG2 bits; advances when a frame completes. Absent when AVG_LOG2 = 0; frm_cnt is treated as 0.
- Accepted input = in_valid && ready_out.
- Accumulator RAM:
  - FFT_SIZE words of DATA_WIDTH+AVG_LOG2 bits.
  - 1 read port with registered output, 1 write port.
  - No reset or clear pass: contents are ignored whenever frm_cnt == 0.
- Pipeline:
  - S1: capture in_data, in_valid, in_last, bin_cnt, frm_cnt; issue RAM read at bin_cnt.
  - S2: base = (frm_cnt == 0) ? 0 : ram_rdata; sum = base + data.
- If S2 frm_cnt != 2^AVG_LOG2 - 1: write sum to RAM[bin]; out_valid = 0.
- If S2 frm_cnt == 2^AVG_LOG2 - 1: RAM is not written.
  - Output register loads out_data = (sum + 2^(AVG_LOG2-1)) >> AVG_LOG2, i.e. round-half-up; plain sum when AVG_LOG2 = 0.
  - out_bin = bin; out_last = (bin == FFT_SIZE-1); out_valid = 1.
- Frame completion, on an accepted input with bin_cnt == FFT_SIZE-1:
  - bin_cnt wraps to 0.
  - frm_cnt increments, wrapping 2^AVG_LOG2-1 -> 0.
- Length check:
  - Accepted in_last with bin_cnt != FFT_SIZE-1 is a short frame.
  - bin_cnt == FFT_SIZE-1 accepted without in_last is a long frame.
  - Both cases pulse err_len, force bin_cnt = 0 and frm_cnt = 0.
  - The offending sample is still processed as its captured bin/frame.
  - The next frame restarts a fresh averaging group; a partial group is never output.
- Read-after-write: consecutive bins always address different words because FFT_SIZE >= 4. No bypass logic is required.
- Width rule: sum is DATA_WIDTH+AVG_LOG2 bits and cannot overflow. The rounded result always fits DATA_WIDTH bits, so no saturation is needed.

## Timing
- Latency: accepted input at cycle t -> out_valid at t+2 (stall cycles excluded).
- ready_out low:
  - All pipeline registers, counters and outputs hold.
  - RAM read output holds and RAM writes are suppressed.
  - Inputs are not accepted. err_len is held low during the stall and fires on the accepting edge.
- in_valid low with ready_out high inserts a bubble that propagates as out_valid = 0. Counters hold.
- Throughput: one bin per cycle sustained, back-to-back frames, no gap needed between frames.
- Reset values: out_valid 0, out_last 0, out_bin 0, out_data 0, err_len 0, bin_cnt 0, frm_cnt 0, pipeline valids 0.
- Reset mid-frame abandons the partial group. RAM contents may remain but are ignored because frm_cnt restarts at 0.

## Test plan
- Test 1: AVG_LOG2=2, FFT_SIZE=8, four frames with bin k = 100+k in every frame -> one output frame 100..107, bins 0..7, out_last on bin 7. No outputs during frames 1-3.
- Test 2: rounding. Bin 0 values 1,1,1,0 -> out_data 1 (3+2>>2). Bin 1 values 65535 x4 -> 65535. Bin 2 values 0,0,0,1 -> 0.
- Test 3: random ready_out stalls (30%) and in_valid gaps over eight frames. Output stream must match the unstalled golden model bit-exactly, with a 2-cycle accepted-to-output latency.
- Test 4: short frame, in_last at bin 5 of frame 2 -> single err_len pulse. The next four full frames produce exactly one correct averaged frame, with no stale data from the aborted group.
- Test 5: resetn low for one cycle mid-frame 3 -> all outputs 0 next cycle. The following four frames average correctly.
- Test 6: AVG_LOG2=0 -> every frame is passed through unchanged with 2-cycle latency, out_bin 0..FFT_SIZE-1.

Source files
------------

// File: rtl/log_spec_averager.sv
// log_spec_averager
//   Averages each FFT bin of the log2-magnitude stream over 2^AVG_LOG2
//   consecutive frames. Partial sums live in an accumulator RAM. On the
//   last frame of each group, one averaged frame is streamed out bin by bin
//   with round-half-up. ready_out is a global stall: when it is low, every
//   register holds and RAM writes are suppressed.
//
// Ports
//   clk, resetn          clock; synchronous active-low reset
//   ready_out / ready_in downstream ready (low = stall); ready_in mirrors it
//   in_valid/in_last     input bin qualifier / last bin of frame
//   in_data              unsigned log2 magnitude
//   out_valid/out_last   averaged bin valid / last bin of averaged frame
//   out_bin, out_data    bin index and averaged value
//   err_len              one-cycle pulse on a short or long frame
//
// Handshake: an input is accepted on a rising edge where
// in_valid && ready_out. An accepted bin appears on the outputs two
// ready cycles later. Output registers update only on edges where
// ready_out is high.
module log_spec_averager #(
  parameter int DATA_WIDTH = 16,
  parameter int FFT_SIZE   = 256,
  parameter int AVG_LOG2   = 2
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic                        ready_out,
  output logic                        ready_in,
  input  logic                        in_valid,
  input  logic                        in_last,
  input  logic [DATA_WIDTH-1:0]       in_data,
  output logic                        out_valid,
  output logic                        out_last,
  output logic [$clog2(FFT_SIZE)-1:0] out_bin,
  output logic [DATA_WIDTH-1:0]       out_data,
  output logic                        err_len
);
  localparam int BW = $clog2(FFT_SIZE);
  // The frame counter keeps one dummy bit when AVG_LOG2 = 0. That bit
  // stays 0 because FRM_LAST is 0, so every frame is the final frame.
  localparam int FW = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int SW = DATA_WIDTH + AVG_LOG2;
  localparam logic [BW-1:0] BIN_LAST = BW'(FFT_SIZE - 1);
  localparam logic [FW-1:0] FRM_LAST = FW'((1 << AVG_LOG2) - 1);
  localparam logic [SW-1:0] HALF     = SW'((1 << AVG_LOG2) >> 1);

  logic [BW-1:0] bin_cnt;
  logic [FW-1:0] frm_cnt;
  logic          accept;
  logic          at_end;
  logic          len_err;

  assign ready_in = ready_out;
  assign accept   = in_valid && ready_out;
  assign at_end   = (bin_cnt == BIN_LAST);
  // A short frame (in_last early) and a long frame (no in_last on the
  // final bin) are both a disagreement between in_last and at_end.
  assign len_err  = accept && (in_last != at_end);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      bin_cnt <= '0;
      frm_cnt <= '0;
    end else if (accept) begin
      if (in_last != at_end) begin
        bin_cnt <= '0;
        frm_cnt <= '0;
      end else if (at_end) begin
        bin_cnt <= '0;
        frm_cnt <= (frm_cnt == FRM_LAST) ? '0 : frm_cnt + FW'(1);
      end else begin
        bin_cnt <= bin_cnt + BW'(1);
      end
    end
  end

  // Stage 1: capture the sample and its bin/frame position.
  logic                  s1_valid;
  logic [DATA_WIDTH-1:0] s1_data;
  logic [BW-1:0]         s1_bin;
  logic [FW-1:0]         s1_frm;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_bin   <= '0;
      s1_frm   <= '0;
    end else if (ready_out) begin
      s1_valid <= in_valid;
      s1_data  <= in_data;
      s1_bin   <= bin_cnt;
      s1_frm   <= frm_cnt;
    end
  end

  // The accumulator RAM is never cleared. Words are overwritten on the
  // first frame of each group because the base is forced to zero there.
  // The read and write addresses always differ: stage 2 writes bin k while
  // stage 1 reads bin k+1.
  logic [SW-1:0] mem [FFT_SIZE];
  logic [SW-1:0] rd_q;
  logic          s2_final;
  logic          ram_we;
  logic [SW-1:0] base;
  logic [SW-1:0] sum;

  assign s2_final = (s1_frm == FRM_LAST);
  assign ram_we   = resetn && ready_out && s1_valid && !s2_final;
  assign base     = (s1_frm == '0) ? '0 : rd_q;
  assign sum      = base + SW'(s1_data);

  always_ff @(posedge clk) begin
    if (ready_out) begin
      rd_q <= mem[bin_cnt];
    end
  end

  always_ff @(posedge clk) begin
    if (ram_we) begin
      mem[s1_bin] <= sum;
    end
  end

  // Stage 2 output register. sum + HALF cannot overflow SW bits, and the
  // shifted result always fits DATA_WIDTH bits.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_bin   <= '0;
      out_data  <= '0;
      err_len   <= 1'b0;
    end else begin
      // len_err is already low during a stall, so the pulse cannot stretch.
      err_len <= len_err;
      if (ready_out) begin
        out_valid <= s1_valid && s2_final;
        if (s1_valid && s2_final) begin
          out_data <= DATA_WIDTH'((sum + HALF) >> AVG_LOG2);
          out_bin  <= s1_bin;
          out_last <= (s1_bin == BIN_LAST);
        end
      end
    end
  end
endmodule

// File: tb/tb_log_spec_averager.sv
// Bench for log_spec_averager. A single stimulus stream drives two
// instances: dut_a averages over 4 frames and dut_b passes frames through
// (AVG_LOG2 = 0). Both use FFT_SIZE = 8. Expected outputs are pushed into
// queues when inputs are accepted, and popped when the DUTs produce output.
module tb_log_spec_averager;
  localparam int DW  = 16;
  localparam int FFT = 8;
  localparam int BW  = 3;
  localparam int N   = 4;
  localparam int EW  = 1 + BW + DW;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          resetn, ready_out, in_valid, in_last;
  logic [DW-1:0] in_data;
  logic          ready_in_a, out_valid_a, out_last_a, err_len_a;
  logic [BW-1:0] out_bin_a;
  logic [DW-1:0] out_data_a;
  logic          ready_in_b, out_valid_b, out_last_b, err_len_b;
  logic [BW-1:0] out_bin_b;
  logic [DW-1:0] out_data_b;

  log_spec_averager #(.DATA_WIDTH(DW), .FFT_SIZE(FFT), .AVG_LOG2(2)) dut_a (
    .clk(clk), .resetn(resetn), .ready_out(ready_out), .ready_in(ready_in_a),
    .in_valid(in_valid), .in_last(in_last), .in_data(in_data),
    .out_valid(out_valid_a), .out_last(out_last_a), .out_bin(out_bin_a),
    .out_data(out_data_a), .err_len(err_len_a));

  log_spec_averager #(.DATA_WIDTH(DW), .FFT_SIZE(FFT), .AVG_LOG2(0)) dut_b (
    .clk(clk), .resetn(resetn), .ready_out(ready_out), .ready_in(ready_in_b),
    .in_valid(in_valid), .in_last(in_last), .in_data(in_data),
    .out_valid(out_valid_b), .out_last(out_last_b), .out_bin(out_bin_b),
    .out_data(out_data_b), .err_len(err_len_b));

  // scoreboard
  int checks = 0;
  int errors = 0;
  int rcnt   = 0;
  logic [EW-1:0] exp_q_a[$];
  logic [EW-1:0] exp_q_b[$];
  int due_a[$];
  int due_b[$];
  int m_bin = 0;
  int m_frm = 0;
  int m_sum[FFT];
  int r0[4] = '{1, 1, 1, 0};
  int r2[4] = '{0, 0, 0, 1};
  bit stress = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic mon_a();
    logic [EW-1:0] e;
    int d;
    if (out_valid_a) begin
      if (exp_q_a.size() == 0) begin
        chk("a_spurious_valid", 32'(out_valid_a), 32'(0));
      end else begin
        e = exp_q_a.pop_front();
        d = due_a.pop_front();
        chk("a_data", 32'(out_data_a), 32'(e[DW-1:0]));
        chk("a_bin", 32'(out_bin_a), 32'(e[DW+BW-1:DW]));
        chk("a_last", 32'(out_last_a), 32'(e[EW-1]));
        chk("a_latency", 32'(rcnt), 32'(d));
      end
    end else if (due_a.size() > 0 && due_a[0] <= rcnt) begin
      chk("a_missing_valid", 32'(out_valid_a), 32'(1));
      void'(exp_q_a.pop_front());
      void'(due_a.pop_front());
    end
  endtask

  task automatic mon_b();
    logic [EW-1:0] e;
    int d;
    if (out_valid_b) begin
      if (exp_q_b.size() == 0) begin
        chk("b_spurious_valid", 32'(out_valid_b), 32'(0));
      end else begin
        e = exp_q_b.pop_front();
        d = due_b.pop_front();
        chk("b_data", 32'(out_data_b), 32'(e[DW-1:0]));
        chk("b_bin", 32'(out_bin_b), 32'(e[DW+BW-1:DW]));
        chk("b_last", 32'(out_last_b), 32'(e[EW-1]));
        chk("b_latency", 32'(rcnt), 32'(d));
      end
    end else if (due_b.size() > 0 && due_b[0] <= rcnt) begin
      chk("b_missing_valid", 32'(out_valid_b), 32'(1));
      void'(exp_q_b.pop_front());
      void'(due_b.pop_front());
    end
  endtask

  // driver: one clock cycle, with the model updated on acceptance
  task automatic step(input logic v, input logic l, input logic [DW-1:0] d, input logic r);
    logic acc, mis;
    int s;
    in_valid = v; in_last = l; in_data = d; ready_out = r;
    @(posedge clk);
    acc = v && r;
    mis = 1'b0;
    if (r) rcnt++;
    if (acc) begin
      mis = (l != (m_bin == FFT - 1));
      s = (m_frm == 0) ? int'(d) : m_sum[m_bin] + int'(d);
      m_sum[m_bin] = s;
      if (m_frm == N - 1) begin
        exp_q_a.push_back({m_bin == FFT - 1, BW'(m_bin), DW'((s + N / 2) / N)});
        due_a.push_back(rcnt + 1);
      end
      exp_q_b.push_back({m_bin == FFT - 1, BW'(m_bin), d});
      due_b.push_back(rcnt + 1);
      if (mis) begin
        m_bin = 0; m_frm = 0;
      end else if (m_bin == FFT - 1) begin
        m_bin = 0; m_frm = (m_frm + 1) % N;
      end else begin
        m_bin++;
      end
    end
    @(negedge clk);
    chk("ready_in", 32'(ready_in_a), 32'(r));
    chk("a_err_len", 32'(err_len_a), 32'(mis));
    chk("b_err_len", 32'(err_len_b), 32'(mis));
    if (r) begin
      mon_a();
      mon_b();
    end
  endtask

  task automatic rst_step();
    resetn = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = '0; ready_out = 1'b1;
    @(posedge clk);
    m_bin = 0; m_frm = 0;
    exp_q_a.delete(); due_a.delete(); exp_q_b.delete(); due_b.delete();
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid_a), 32'(0));
    chk("rst_out_last", 32'(out_last_a), 32'(0));
    chk("rst_out_bin", 32'(out_bin_a), 32'(0));
    chk("rst_out_data", 32'(out_data_a), 32'(0));
    chk("rst_err_len", 32'(err_len_a), 32'(0));
    chk("rst_b_out_valid", 32'(out_valid_b), 32'(0));
    resetn = 1'b1;
  endtask

  task automatic send(input logic l, input logic [DW-1:0] d);
    if (stress) begin
      while ($urandom_range(0, 99) < 30) step(1'($urandom_range(0, 1)), l, d, 1'b0);
      if ($urandom_range(0, 99) < 20) step(1'b0, 1'b0, '0, 1'b1);
    end
    step(1'b1, l, d, 1'b1);
  endtask

  // kind 0: 100+k; 1: rounding patterns; 2: random.
  // cut >= 0 ends the frame early with in_last on that bin.
  task automatic frame(input int kind, input int f, input int cut, input bit no_last);
    for (int k = 0; k < FFT; k++) begin
      logic [DW-1:0] d;
      logic l;
      case (kind)
        0: d = DW'(100 + k);
        1: d = (k == 0) ? DW'(r0[f]) : (k == 1) ? 16'hFFFF : (k == 2) ? DW'(r2[f]) : DW'($urandom);
        default: d = DW'($urandom);
      endcase
      l = (k == cut) || (k == FFT - 1 && !no_last);
      send(l, d);
      if (k == cut) break;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, 1'b1);
  endtask

  initial begin
    resetn = 1'b0; ready_out = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = '0;
    rst_step();

    // basic four-frame average of 100+k
    for (int f = 0; f < 4; f++) frame(0, f, -1, 1'b0);
    idle(3);
    chk("t1_drained", 32'(exp_q_a.size()), 32'(0));

    // rounding
    for (int f = 0; f < 4; f++) frame(1, f, -1, 1'b0);
    idle(3);

    // random stalls and bubbles
    stress = 1'b1;
    for (int f = 0; f < 8; f++) frame(2, f, -1, 1'b0);
    stress = 1'b0;
    idle(3);

    // short frame in frame 2, then four full frames
    frame(2, 0, -1, 1'b0);
    frame(2, 1, 5, 1'b0);
    for (int f = 0; f < 4; f++) frame(2, f, -1, 1'b0);
    // long frame, then a fresh group
    frame(2, 0, -1, 1'b1);
    for (int f = 0; f < 4; f++) frame(2, f, -1, 1'b0);
    idle(3);

    // reset in the middle of frame 3
    frame(2, 0, -1, 1'b0);
    frame(2, 1, -1, 1'b0);
    for (int k = 0; k < 3; k++) step(1'b1, 1'b0, DW'($urandom), 1'b1);
    rst_step();
    for (int f = 0; f < 4; f++) frame(0, f, -1, 1'b0);
    idle(3);
    chk("end_drained_a", 32'(exp_q_a.size()), 32'(0));
    chk("end_drained_b", 32'(exp_q_b.size()), 32'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
